// File: rtl/prescaled_timer_ctrl.sv
// Prescaled one-shot/periodic timer controller: a modulo-PRESCALE prescaler
// gates a W-bit down-counter and emits a registered expire pulse.
module prescaled_timer_ctrl #(
  parameter int PRESCALE = 10,
  parameter int W        = 8
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         mode,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         tick,
  output logic         expire,
  output logic [W-1:0] count,
  output logic [1:0]   state
);

  localparam int PW = (PRESCALE <= 2) ? 1 : $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  reload_q, reload_d;
  logic          mode_q, mode_d;
  logic          expire_d;
  logic          start_ok;

  // Strobes are sampled every cycle with priority stop > start > pause > tick;
  // a start carrying load_val==0 is treated as if it were absent.
  assign start_ok = start && (load_val != '0);

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    expire_d = 1'b0;
    tick     = 1'b0;
    if (stop) begin
      state_d = IDLE;
      pre_d   = '0;
      count_d = '0;
    end else if (start_ok) begin
      reload_d = load_val;
      mode_d   = mode;
      count_d  = load_val;
      pre_d    = '0;
      state_d  = RUN;
    end else if (state_q == RUN || state_q == PAUSE) begin
      if (pause) begin
        state_d = PAUSE;
      end else begin
        // The cycle leaving PAUSE already counts as a running cycle.
        state_d = RUN;
        if (pre_q == PRE_MAX) begin
          tick  = 1'b1;
          pre_d = '0;
          if (count_q > W'(1)) begin
            count_d = count_q - W'(1);
          end else if (count_q == W'(1)) begin
            expire_d = 1'b1;
            if (mode_q) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = DONE;
            end
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      expire   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      expire   <= expire_d;
    end
  end

  assign busy  = (state_q == RUN) || (state_q == PAUSE);
  assign count = count_q;
  assign state = state_q;

endmodule

// File: tb/tb_prescaled_timer_ctrl.sv
// Directed bench for prescaled_timer_ctrl (PRESCALE=4): expected tick/expire
// cycles are queued at stimulus time and popped by an independent monitor.
module tb_prescaled_timer_ctrl;
  localparam int PRESCALE = 4;
  localparam int W        = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic         clk = 1'b0;
  logic         areset = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         busy, tick, expire;
  logic [W-1:0] count;
  logic [1:0]   state;

  logic [31:0] cyc = 0;
  logic [31:0] base = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] tick_q[$];
  logic [31:0] exp_q[$];

  prescaled_timer_ctrl #(.PRESCALE(PRESCALE), .W(W)) dut (
    .clk(clk), .areset(areset), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .load_val(load_val), .busy(busy), .tick(tick),
    .expire(expire), .count(count), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // monitor: pops expected cycle numbers whenever tick or expire is seen
  always begin
    @(negedge clk);
    #2;
    if (tick) begin
      if (tick_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tick_unexpected actual=%0d required=none", cyc);
      end else chk("tick_cycle", cyc, tick_q.pop_front());
    end
    if (expire) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL expire_unexpected actual=%0d required=none", cyc);
      end else chk("expire_cycle", cyc, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic wait_to(input int c);
    while (cyc < base + c) @(negedge clk);
  endtask

  task automatic check_at(input string tag, input int c, input logic [1:0] st,
                          input logic [W-1:0] cnt, input logic bsy);
    wait_to(c);
    #2;
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_count"}, 32'(count), 32'(cnt));
    chk({tag, "_busy"}, 32'(busy), 32'(bsy));
  endtask

  task automatic do_start(input logic [W-1:0] lv, input logic md);
    @(negedge clk);
    start = 1'b1; load_val = lv; mode = md;
    base = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_tick(input int c);
    tick_q.push_back(base + 32'(c));
  endtask

  task automatic push_exp(input int c);
    exp_q.push_back(base + 32'(c));
  endtask

  task automatic sc_oneshot(input string tag);
    do_start(8'd3, 1'b0);
    push_tick(4); push_tick(8); push_tick(12); push_exp(13);
    check_at({tag, "_c1"}, 1, S_RUN, 8'd3, 1'b1);
    check_at({tag, "_c5"}, 5, S_RUN, 8'd2, 1'b1);
    check_at({tag, "_c9"}, 9, S_RUN, 8'd1, 1'b1);
    check_at({tag, "_c13"}, 13, S_DONE, 8'd0, 1'b0);
    check_at({tag, "_c16"}, 16, S_DONE, 8'd0, 1'b0);
  endtask

  initial begin
    #7;
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_expire", 32'(expire), 0);
    @(negedge clk);
    areset = 1'b1;
    repeat (2) @(negedge clk);

    sc_oneshot("oneshot");

    // periodic: expire every 12 cycles, count reloads
    do_start(8'd3, 1'b1);
    for (int k = 1; k <= 9; k++) push_tick(4 * k);
    push_exp(13); push_exp(25); push_exp(37);
    check_at("per_c13", 13, S_RUN, 8'd3, 1'b1);
    check_at("per_c37", 37, S_RUN, 8'd3, 1'b1);
    wait_to(38);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_at("per_stop", 39, S_IDLE, 8'd0, 1'b0);

    // pause for cycles 5..9
    do_start(8'd3, 1'b0);
    push_tick(4); push_tick(13); push_tick(17); push_exp(18);
    wait_to(5);
    pause = 1'b1;
    check_at("pause_c6", 6, S_PAUSE, 8'd2, 1'b1);
    wait_to(10);
    pause = 1'b0;
    check_at("pause_c10", 10, S_PAUSE, 8'd2, 1'b1);
    check_at("pause_c11", 11, S_RUN, 8'd2, 1'b1);
    check_at("pause_c14", 14, S_RUN, 8'd1, 1'b1);
    check_at("pause_c18", 18, S_DONE, 8'd0, 1'b0);

    // stop beats start; zero-load start ignored
    do_start(8'd3, 1'b0);
    push_tick(4);
    wait_to(6);
    stop = 1'b1; start = 1'b1; load_val = 8'd5;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    check_at("stopstart_c7", 7, S_IDLE, 8'd0, 1'b0);
    wait_to(9);
    start = 1'b1; load_val = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check_at("zeroload_c10", 10, S_IDLE, 8'd0, 1'b0);
    check_at("zeroload_c12", 12, S_IDLE, 8'd0, 1'b0);

    // restart mid-run with load 2
    do_start(8'd3, 1'b0);
    push_tick(4); push_tick(8); push_tick(14); push_tick(18); push_exp(19);
    check_at("restart_c9", 9, S_RUN, 8'd1, 1'b1);
    wait_to(10);
    start = 1'b1; load_val = 8'd2; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_at("restart_c11", 11, S_RUN, 8'd2, 1'b1);
    check_at("restart_c15", 15, S_RUN, 8'd1, 1'b1);
    check_at("restart_c19", 19, S_DONE, 8'd0, 1'b0);

    // async reset mid periodic run
    do_start(8'd3, 1'b1);
    push_tick(4);
    wait_to(7);
    areset = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'(S_IDLE));
    chk("arst_count", 32'(count), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_expire", 32'(expire), 0);
    chk("arst_tick", 32'(tick), 0);
    repeat (2) @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    sc_oneshot("post_rst");

    repeat (5) @(negedge clk);
    #2;
    chk("tick_q_empty", 32'(tick_q.size()), 0);
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
